// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: FSM state encoding, r_w encoding
// and default bus widths, common to the control unit and the memory target.
package mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  function automatic logic in_range(input logic [31:0] a, input int unsigned depth);
    return a < depth;
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage, synchronous write and registered read (one edge);
// no flow control, out-of-range addresses neither write nor update rdata.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 200
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              hit;

  assign hit = in_range(32'(addr), DEPTH);

  always_ff @(posedge clk) begin
    if (hit) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory target: request sampled in IDLE, access after WAIT_CYC
// wait states, one-cycle ready pulse; new requests are ignored while busy.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = 200,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              r_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              oor_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              access;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_rdata;

  assign accept = (state == ST_IDLE) && req;
  assign access = (state == ST_WAIT) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req)        state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == '0)  state_nxt = ST_RESP;
      ST_RESP:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    err   = 1'b0;
    case (state)
      ST_WAIT: busy = 1'b1;
      ST_RESP: begin
        busy  = 1'b1;
        ready = 1'b1;
        err   = oor_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      rw_q    <= RW_READ;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cnt     <= CNT_INIT;
        addr_q  <= addr;
        rw_q    <= r_w;
        wdata_q <= wdata;
        oor_q   <= !in_range(32'(addr), DEPTH);
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
      if (access) begin
        if (oor_q)                rdata_q <= '0;
        else if (rw_q == RW_READ) rdata_q <= arr_rdata;
      end
    end
  end

  // The array read is registered, so it is pointed at the incoming address on
  // the accept edge; its output is then settled by the access edge even with no wait states.
  assign arr_addr = accept ? addr : addr_q;
  assign arr_we   = access && (rw_q == RW_WRITE) && !oor_q;
  assign rdata    = rdata_q;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule
